// File: rtl/twiddle_sequencer.sv
// ---------------------------------------------------------------------------
// twiddle_sequencer
//
// Produces the per-beat twiddle address stream for a 64-point, 8-lane
// radix-2 FFT. Each beat carries a LUT start index and a per-lane step; the
// sine/cosine LUTs expand that pair into the 8 lane angles (2*pi*idx/64).
// A frame is 6 stages x 4 beats = 24 beats.
//
// Handshake (tw_valid / tw_ready): a beat is presented while tw_valid=1 and
// is transferred on every rising edge where tw_valid and tw_ready are both 1.
// While tw_valid=1 and tw_ready=0 every tw_* output holds stable. tw_valid
// never drops without a transfer. tw_ready while tw_valid=0 is ignored.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   frame_start  in   one-cycle frame request, honoured only while idle
//   inverse      in   captured with an accepted frame_start
//   tw_ready     in   consumer accepts the presented beat
//   tw_valid     out  beat presented
//   tw_start     out  LUT start index (6b)
//   tw_step      out  LUT per-lane index increment (6b, modulo 64)
//   tw_stage     out  stage 0..5
//   tw_beat      out  beat within stage 0..3
//   tw_conj      out  inverse transform flag, constant for the frame
//   tw_last      out  marks stage 5 / beat 3
//   busy         out  frame in progress (state == RUN)
//   done         out  one-cycle pulse after the last beat is transferred
//   dbg_state    out  FSM state (0 = IDLE, 1 = RUN)
//
// All outputs come straight from flops: tw_valid/busy/dbg_state decode the
// state flop, everything else has its own register.
// ---------------------------------------------------------------------------
module twiddle_sequencer #(
  parameter int LOG2N = 6,
  parameter int LANES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       inverse,
  input  logic       tw_ready,
  output logic       tw_valid,
  output logic [5:0] tw_start,
  output logic [5:0] tw_step,
  output logic [2:0] tw_stage,
  output logic [1:0] tw_beat,
  output logic       tw_conj,
  output logic       tw_last,
  output logic       busy,
  output logic       done,
  output logic       dbg_state
);

  // The address tables below are hard-wired for this one geometry.
  generate
    if (LOG2N != 6) begin : g_bad_log2n
      $error("twiddle_sequencer: only LOG2N = 6 is supported");
    end
    if (LANES != 8) begin : g_bad_lanes
      $error("twiddle_sequencer: only LANES = 8 is supported");
    end
  endgenerate

  localparam logic [2:0] LAST_STAGE = 3'd5;
  localparam logic [1:0] LAST_BEAT  = 2'd3;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  logic [5:0] r_tw_start;
  logic [5:0] r_tw_step;
  logic [2:0] r_tw_stage;
  logic [1:0] r_tw_beat;
  logic       r_tw_conj;
  logic       r_tw_last;
  logic       r_done;

  logic [5:0] w_start_nxt;
  logic [5:0] w_step_nxt;
  logic [2:0] w_stage_nxt;
  logic [1:0] w_beat_nxt;
  logic       w_conj_nxt;
  logic       w_last_nxt;
  logic       w_done_nxt;

  logic       w_accept;

  // In RUN the beat is always presented, so a transfer is just ready in RUN.
  assign w_accept = (r_state == S_RUN) && tw_ready;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (frame_start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        // frame_start is deliberately not looked at here: no queueing,
        // even in the cycle the last beat goes out.
        if (w_accept && r_tw_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic: next values of the registered beat fields.
  // Default is hold, which gives stall stability for free.
  // -------------------------------------------------------------------------
  always_comb begin
    w_stage_nxt = r_tw_stage;
    w_beat_nxt  = r_tw_beat;
    w_conj_nxt  = r_tw_conj;
    w_last_nxt  = r_tw_last;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (frame_start) begin
          w_stage_nxt = 3'd0;
          w_beat_nxt  = 2'd0;
          w_conj_nxt  = inverse;
          w_last_nxt  = 1'b0;
        end
      end
      S_RUN: begin
        if (w_accept) begin
          if (r_tw_last) begin
            // Frame complete: park all beat fields at zero while idle.
            w_stage_nxt = 3'd0;
            w_beat_nxt  = 2'd0;
            w_conj_nxt  = 1'b0;
            w_last_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_beat_nxt = r_tw_beat + 2'd1;
            if (r_tw_beat == LAST_BEAT) begin
              w_stage_nxt = r_tw_stage + 3'd1;
            end
            w_last_nxt = (w_stage_nxt == LAST_STAGE) && (w_beat_nxt == LAST_BEAT);
          end
        end
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Address rule, evaluated on the next stage/beat so start/step land in the
  // same cycle as their tags. m = 2^s distinct twiddles per stage:
  //   s <= 2: all lanes share one twiddle, step 0,
  //           start = (b >> (2-s)) * (32 >> s)
  //   s >= 3: step = 32 >> s, start = (b mod 2^(s-3)) * 8 * step
  // Idle parks stage/beat at 0, which maps to start=0 / step=0.
  // -------------------------------------------------------------------------
  always_comb begin
    w_start_nxt = 6'd0;
    w_step_nxt  = 6'd0;
    case (w_stage_nxt)
      3'd0: begin
        w_start_nxt = 6'd0;                               // 0,0,0,0
      end
      3'd1: begin
        w_start_nxt = {1'b0, w_beat_nxt[1], 4'b0000};     // 0,0,16,16
      end
      3'd2: begin
        w_start_nxt = {1'b0, w_beat_nxt, 3'b000};         // 0,8,16,24
      end
      3'd3: begin
        w_step_nxt  = 6'd4;
        w_start_nxt = 6'd0;                               // 0,0,0,0
      end
      3'd4: begin
        w_step_nxt  = 6'd2;
        w_start_nxt = {1'b0, w_beat_nxt[0], 4'b0000};     // 0,16,0,16
      end
      3'd5: begin
        w_step_nxt  = 6'd1;
        w_start_nxt = {1'b0, w_beat_nxt, 3'b000};         // 0,8,16,24
      end
      default: begin
        w_step_nxt  = 6'd0;
        w_start_nxt = 6'd0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tw_start <= 6'd0;
      r_tw_step  <= 6'd0;
      r_tw_stage <= 3'd0;
      r_tw_beat  <= 2'd0;
      r_tw_conj  <= 1'b0;
      r_tw_last  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_tw_start <= w_start_nxt;
      r_tw_step  <= w_step_nxt;
      r_tw_stage <= w_stage_nxt;
      r_tw_beat  <= w_beat_nxt;
      r_tw_conj  <= w_conj_nxt;
      r_tw_last  <= w_last_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign tw_valid  = (r_state == S_RUN);
  assign busy      = (r_state == S_RUN);
  assign dbg_state = r_state;
  assign tw_start  = r_tw_start;
  assign tw_step   = r_tw_step;
  assign tw_stage  = r_tw_stage;
  assign tw_beat   = r_tw_beat;
  assign tw_conj   = r_tw_conj;
  assign tw_last   = r_tw_last;
  assign done      = r_done;

endmodule

// File: tb/tb_twiddle_sequencer.sv
// Bench for twiddle_sequencer: a 24-entry table of expected beats is built
// from the per-stage start lists, loaded into an expected queue per frame and
// popped on every transfer. Hand-written sequences cover reset, stalls,
// ignored frame_start pulses, back-to-back restart and mid-frame reset.
module tb_twiddle_sequencer;

  logic       clk;
  logic       rst;
  logic       frame_start;
  logic       inverse;
  logic       tw_ready;
  logic       tw_valid;
  logic [5:0] tw_start;
  logic [5:0] tw_step;
  logic [2:0] tw_stage;
  logic [1:0] tw_beat;
  logic       tw_conj;
  logic       tw_last;
  logic       busy;
  logic       done;
  logic       dbg_state;

  twiddle_sequencer #(.LOG2N(6), .LANES(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .inverse     (inverse),
    .tw_ready    (tw_ready),
    .tw_valid    (tw_valid),
    .tw_start    (tw_start),
    .tw_step     (tw_step),
    .tw_stage    (tw_stage),
    .tw_beat     (tw_beat),
    .tw_conj     (tw_conj),
    .tw_last     (tw_last),
    .busy        (busy),
    .done        (done),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1, "watchdog");
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0] stage;
    logic [1:0] beat;
    logic [5:0] start;
    logic [5:0] step;
    logic       last;
  } vec_t;

  vec_t tbl[24];
  logic [18:0] exp_q[$];   // {stage, beat, start, step, last, conj}

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [18:0] cur_beat();
    return {tw_stage, tw_beat, tw_start, tw_step, tw_last, tw_conj};
  endfunction

  // ---------------- driver tasks ----------------
  // Each task is entered and left 1 time unit after a rising edge.
  task automatic start_frame(input bit inv);
    frame_start = 1'b1;
    inverse     = inv;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  // Runs one frame from its first valid cycle to one cycle past done.
  // fs_beat: hold frame_start high while that many beats have been taken.
  // fs_last: pulse frame_start in the cycle of the final transfer.
  // fs_in_done: pulse frame_start in the done cycle (restart with next_inv).
  task automatic run_frame(input bit inv, input bit rand_ready, input bit toggle_inv,
                           input int fs_beat, input bit fs_last, input bit fs_in_done,
                           input bit next_inv);
    logic [18:0] cur;
    logic [18:0] held;
    logic [18:0] exp;
    bit have_held = 1'b0;
    bit finished  = 1'b0;
    int accepts   = 0;
    int cyc       = 0;
    int busy_cnt  = 0;
    exp_q.delete();
    for (int i = 0; i < 24; i++)
      exp_q.push_back({tbl[i].stage, tbl[i].beat, tbl[i].start, tbl[i].step, tbl[i].last, inv});
    while (!finished && cyc < 400) begin
      cur = cur_beat();
      check("valid_in_frame", {31'd0, tw_valid}, 32'd1);
      check("busy_done_in_frame", {30'd0, busy, done}, 32'd2);
      if (have_held) check("stall_hold", {13'd0, cur}, {13'd0, held});
      if (busy) busy_cnt++;
      tw_ready    = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      frame_start = (accepts == fs_beat);
      if (toggle_inv) inverse = ~inverse;
      if (tw_ready) begin
        exp = exp_q.pop_front();
        check($sformatf("beat%0d", accepts), {13'd0, cur}, {13'd0, exp});
        if (fs_last && accepts == 23) frame_start = 1'b1;
        accepts++;
        have_held = 1'b0;
        if (accepts == 24) finished = 1'b1;
      end else begin
        held      = cur;
        have_held = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    frame_start = 1'b0;
    check("frame_completed", {31'd0, finished}, 32'd1);
    // Now in the done cycle.
    check("done_pulse", {31'd0, done}, 32'd1);
    check("valid_after_last", {31'd0, tw_valid}, 32'd0);
    check("busy_after_last", {31'd0, busy}, 32'd0);
    if (!rand_ready) begin
      check("busy_cycles", busy_cnt, 32'd24);
      check("done_latency", cyc, 32'd24);
    end
    if (fs_in_done) begin
      frame_start = 1'b1;
      inverse     = next_inv;
    end
    @(posedge clk); #1;
    frame_start = 1'b0;
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("valid_after_done", {31'd0, tw_valid}, {31'd0, fs_in_done});
  endtask

  // ---------------- test sequence ----------------
  int starts[6][4] = '{'{0, 0, 0, 0}, '{0, 0, 16, 16}, '{0, 8, 16, 24},
                       '{0, 0, 0, 0}, '{0, 16, 0, 16}, '{0, 8, 16, 24}};
  int steps[6]     = '{0, 0, 0, 4, 2, 1};

  initial begin
    for (int s = 0; s < 6; s++) begin
      for (int b = 0; b < 4; b++) begin
        tbl[s*4+b].stage = 3'(s);
        tbl[s*4+b].beat  = 2'(b);
        tbl[s*4+b].start = 6'(starts[s][b]);
        tbl[s*4+b].step  = 6'(steps[s]);
        tbl[s*4+b].last  = (s == 5 && b == 3);
      end
    end

    rst = 1'b1; frame_start = 1'b0; inverse = 1'b0; tw_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs",
          {12'd0, tw_valid, tw_start, tw_step, tw_stage, tw_beat, tw_conj, tw_last, busy, done, dbg_state},
          32'd0);
    rst = 1'b0;

    // Ready high while idle has no effect.
    tw_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_ready_ignored", {30'd0, tw_valid, busy}, 32'd0);

    // Forward frame, ready held high.
    start_frame(1'b0);
    check("run_state", {31'd0, dbg_state}, 32'd1);
    run_frame(1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b0);

    // Inverse frame, inverse toggling mid-frame.
    start_frame(1'b1);
    run_frame(1'b1, 1'b0, 1'b1, -1, 1'b0, 1'b0, 1'b0);

    // Random ready, about 50% duty.
    start_frame(1'b0);
    run_frame(1'b0, 1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b0);

    // Ignored pulses at beat 5 and at the last transfer; restart in done cycle.
    start_frame(1'b0);
    run_frame(1'b0, 1'b0, 1'b0, 5, 1'b1, 1'b1, 1'b1);
    run_frame(1'b1, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b0);

    // Reset while stalled at stage 3, beat 2.
    start_frame(1'b1);
    tw_ready = 1'b1;
    repeat (14) @(posedge clk);
    #1;
    tw_ready = 1'b0;
    check("pre_rst_pos", {27'd0, tw_valid, tw_stage, tw_beat}, {27'd0, 1'b1, 3'd3, 2'd2});
    @(posedge clk); #1;
    check("pre_rst_stall", {20'd0, tw_stage, tw_beat, tw_start, tw_step, tw_conj},
          {20'd0, 3'd3, 2'd2, 6'd0, 6'd4, 1'b1});
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_outs",
          {12'd0, tw_valid, tw_start, tw_step, tw_stage, tw_beat, tw_conj, tw_last, busy, done, dbg_state},
          32'd0);
    @(posedge clk); #1;
    check("mid_rst_no_done", {30'd0, done, tw_valid}, 32'd0);
    start_frame(1'b0);
    run_frame(1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
